bcd_convert_seq: RTL and testbench

//  Parametrised sequential binary-to-BCD converter for score/counter readouts.

---
 rtl/bcd_convert_seq.sv | 171 +++++++++++++++++
 tb/tb_bcd_convert_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq
//   Iterative binary-to-BCD converter (double dabble, one input bit per
//   clock) for score/timer readouts feeding the 7-segment digit multiplexer.
//   A conversion takes BIN_W clocks. It then holds its result until the
//   consumer takes it. Inputs that exceed DIGITS decimal digits saturate
//   to all nines and raise overflow.
//
// Parameters
//   BIN_W   width of the unsigned binary input
//   DIGITS  number of BCD digits presented on bcd (digit 0 = ones)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   bin is valid
//   in_ready   converter idle, accepts bin
//   bin        unsigned binary value, sampled only on the accept edge
//   out_valid  bcd / overflow are valid
//   out_ready  consumer takes the result
//   bcd        packed BCD, bcd[3:0] = ones
//   overflow   bin >= 10**DIGITS (bcd saturated to all 9s)
//
// Build option
//   LZ_BLANK_EN  when defined, leading zero digits (never digit 0) are
//                replaced by 4'hF, the segment decoder's blank code.
//                Digits are not blanked when the result overflows.
module bcd_convert_seq #(
  parameter int BIN_W  = 15,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  // Digits needed to hold 2**BIN_W-1 (log10(2) ~ 0.31). The accumulator
  // is never narrower than the output so that small BIN_W stays legal.
  localparam int INT_DIG_RAW = (BIN_W * 31) / 100 + 1;
  localparam int INT_DIG     = (INT_DIG_RAW > DIGITS) ? INT_DIG_RAW : DIGITS;
  localparam int ACC_W       = 4 * INT_DIG;
  localparam int CNT_W       = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [BIN_W-1:0]   shift_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [ACC_W-1:0]       acc_add;
  logic [ACC_W+BIN_W-1:0] step_cat;
  logic [ACC_W-1:0]       acc_step;
  logic [BIN_W-1:0]       shift_step;
  logic [4*DIGITS:0]      load_val;

  // Adds 3 to every accumulator digit that is 5 or more, so the following
  // doubling carries correctly into the next decimal digit.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < INT_DIG; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef LZ_BLANK_EN
  // Blanks the contiguous run of most-significant zero digits. Digit 0 is kept.
  function automatic logic [4*DIGITS-1:0] blank_lz(input logic [4*DIGITS-1:0] b);
    logic [4*DIGITS-1:0] r;
    logic                lead;
    r    = b;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (b[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
      else                                lead        = 1'b0;
    end
    return r;
  endfunction
`endif

  // Saturating output formatter: returns {overflow, bcd}.
  function automatic logic [4*DIGITS:0] load_out(input logic [ACC_W-1:0] acc);
    logic                ovf;
    logic [4*DIGITS-1:0] d;
    ovf = 1'b0;
    for (int i = DIGITS; i < INT_DIG; i++) begin
      if (acc[4*i +: 4] != 4'd0) ovf = 1'b1;
    end
    if (ovf) begin
      d = {DIGITS{4'h9}};
    end else begin
      d = acc[4*DIGITS-1:0];
`ifdef LZ_BLANK_EN
      d = blank_lz(d);
`endif
    end
    return {ovf, d};
  endfunction

  // ---- combinational step: add-3 correction, then shift {acc,shift} left
  always_comb begin
    acc_add    = add3(acc_q);
    step_cat   = {acc_add, shift_q} << 1;
    acc_step   = step_cat[ACC_W+BIN_W-1:BIN_W];
    shift_step = step_cat[BIN_W-1:0];
    load_val   = load_out(acc_step);
  end

  // ---- next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)          state_d = S_CONV;
      S_CONV:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  if (out_ready)         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---- datapath registers: accept, iterate, load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shift_q <= bin;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        S_CONV: begin
          acc_q   <= acc_step;
          shift_q <= shift_step;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            overflow <= load_val[4*DIGITS];
            bcd      <= load_val[4*DIGITS-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_convert_seq.sv
module tb_bcd_convert_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] bcd;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int prev_cyc = 0;

`ifdef LZ_BLANK_EN
  localparam logic [15:0] E0   = 16'hFFF0;
  localparam logic [15:0] E42  = 16'hFF42;
  localparam logic [15:0] E7   = 16'hFFF7;
  localparam logic [15:0] E321 = 16'hF321;
`else
  localparam logic [15:0] E0   = 16'h0000;
  localparam logic [15:0] E42  = 16'h0042;
  localparam logic [15:0] E7   = 16'h0007;
  localparam logic [15:0] E321 = 16'h0321;
`endif

  bcd_convert_seq #(.BIN_W(15), .DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference by division: returns {overflow, bcd}.
  function automatic logic [16:0] ref_conv(input int v);
    logic [15:0] r;
    logic        lead;
    if (v >= 10000) return {1'b1, 16'h9999};
    r = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    lead = 1'b1;
`ifdef LZ_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else                             lead        = 1'b0;
    end
`endif
    return {1'b0, r};
  endfunction

  // Accepts one value, checks latency and result. If out_ready is high the
  // result is retired and out_valid must drop after exactly one cycle.
  task automatic do_conv(input string tag, input logic [14:0] b,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
    check({tag, "_in_ready"}, in_ready, 1);
    bin      = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    bin      = 15'($urandom);   // must have no effect after acceptance
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    check({tag, "_latency"}, k, 15);
    check({tag, "_bcd"}, bcd, exp_bcd);
    check({tag, "_ovf"}, overflow, exp_ovf);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_retire"}, out_valid, 0);
    end
  endtask

  initial begin
    logic [16:0] r;
    int          v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bin       = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd", bcd, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_conv("d1234", 15'd1234, 16'h1234, 1'b0);
    do_conv("d9999", 15'd9999, 16'h9999, 1'b0);
    do_conv("d10000", 15'd10000, 16'h9999, 1'b1);
    do_conv("d32767", 15'd32767, 16'h9999, 1'b1);
    do_conv("d0", 15'd0, E0, 1'b0);
    do_conv("d42", 15'd42, E42, 1'b0);

    // Backpressure: hold result for 20 cycles while a new request is offered
    out_ready = 1'b0;
    do_conv("bp", 15'd1234, 16'h1234, 1'b0);
    in_valid = 1'b1;
    bin      = 15'd7;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_bcd_hold", bcd, 16'h1234);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_bcd", bcd, 16'h1234);
    in_valid = 1'b0;
    do_conv("bp7", 15'd7, E7, 1'b0);

    // Reset in the middle of a conversion
    bin      = 15'd5555;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_bcd", bcd, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_conv("post_rst", 15'd321, E321, 1'b0);

    // Back-to-back random values against the division model
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 32767));
      r = ref_conv(v);
      do_conv("rnd", 15'(v), r[15:0], r[16]);
      if (i > 0) check("rnd_throughput", acc_cyc - prev_cyc, 17);
      prev_cyc = acc_cyc;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
